mem_stage_responder: RTL and testbench

Memory-side responder for the multi-cycle core's MEM stage. Accepts a single-cycle load/store request from the stage control path and performs the access on a word-wide, byte-enabled synchronous RAM with a fixed read latency. Returns a one-cycle `ack` with extended load data or an error flag. The stage controller can therefore wait on `ack` instead of relying on a hard-coded MEM_WAIT slot.

---
 rtl/mem_stage_responder.sv | 158 +++++++++++++++
 tb/tb_mem_stage_responder.sv | 381 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_stage_responder.sv
// MEM-stage responder: runs one load/store on a byte-enabled synchronous RAM
// with fixed read latency and returns a one-cycle ack with extended data or err.
module mem_stage_responder #(
  parameter int ADDR_W = 14,
  parameter int RD_LAT = 2
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              req,
  input  logic              req_we,
  input  logic [2:0]        req_funct3,
  input  logic [31:0]       req_addr,
  input  logic [31:0]       req_wdata,
  output logic              busy,
  output logic              ack,
  output logic              err,
  output logic [31:0]       rdata,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_we,
  output logic [3:0]        ram_be,
  output logic [31:0]       ram_wdata,
  input  logic [31:0]       ram_rdata
);

  typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE, S_ERR} state_t;

  // The counter only has to reach RD_LAT-1: the ISSUE cycle counts as the first.
  localparam int CNT_W = (RD_LAT < 2) ? 1 : $clog2(RD_LAT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(RD_LAT - 1);

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_we;
  logic [2:0]       r_f3;
  logic [1:0]       r_off;

  logic w_ok;
  logic w_unused_addr;

  function automatic logic f3_legal(input logic we, input logic [2:0] f3);
    case (f3)
      3'b000, 3'b001, 3'b010: return 1'b1;
      3'b100, 3'b101:         return !we;
      default:                return 1'b0;
    endcase
  endfunction

  function automatic logic misaligned(input logic [2:0] f3, input logic [1:0] off);
    return ((f3[1:0] == 2'b01) && off[0]) || ((f3[1:0] == 2'b10) && (off != 2'b00));
  endfunction

  function automatic logic [3:0] store_be(input logic [2:0] f3, input logic [1:0] off);
    case (f3[1:0])
      2'b00:   return 4'b0001 << off;
      2'b01:   return 4'b0011 << off;
      default: return 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] store_data(input logic [2:0] f3, input logic [31:0] wd);
    case (f3[1:0])
      2'b00:   return {4{wd[7:0]}};
      2'b01:   return {2{wd[15:0]}};
      default: return wd;
    endcase
  endfunction

  function automatic logic [31:0] load_extend(input logic [2:0] f3, input logic [1:0] off,
                                              input logic [31:0] word);
    logic [7:0]  b;
    logic [15:0] h;
    case (off)
      2'd0:    b = word[7:0];
      2'd1:    b = word[15:8];
      2'd2:    b = word[23:16];
      default: b = word[31:24];
    endcase
    h = off[1] ? word[31:16] : word[15:0];
    // funct3[2] distinguishes the unsigned variants (LBU/LHU)
    case (f3[1:0])
      2'b00:   return {{24{~f3[2] & b[7]}}, b};
      2'b01:   return {{16{~f3[2] & h[15]}}, h};
      default: return word;
    endcase
  endfunction

  assign w_ok          = f3_legal(req_we, req_funct3) && !misaligned(req_funct3, req_addr[1:0]);
  assign w_unused_addr = ^req_addr[31:ADDR_W+2];

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_we      <= 1'b0;
      r_f3      <= 3'b000;
      r_off     <= 2'b00;
      busy      <= 1'b0;
      ack       <= 1'b0;
      err       <= 1'b0;
      rdata     <= '0;
      ram_addr  <= '0;
      ram_we    <= 1'b0;
      ram_be    <= 4'b0000;
      ram_wdata <= '0;
    end else begin
      ram_we <= 1'b0;
      ack    <= 1'b0;
      err    <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (req) begin
            busy  <= 1'b1;
            r_we  <= req_we;
            r_f3  <= req_funct3;
            r_off <= req_addr[1:0];
            r_cnt <= '0;
            if (!w_ok) begin
              r_state <= S_ERR;
              ack     <= 1'b1;
              err     <= 1'b1;
            end else begin
              // RAM strobes are registered here so they appear in the ISSUE cycle
              r_state  <= S_ISSUE;
              ram_addr <= req_addr[ADDR_W+1:2];
              ram_we   <= req_we;
              if (req_we) begin
                ram_be    <= store_be(req_funct3, req_addr[1:0]);
                ram_wdata <= store_data(req_funct3, req_wdata);
              end
            end
          end
        end
        S_ISSUE, S_WAIT: begin
          if (r_we) begin
            r_state <= S_DONE;
            ack     <= 1'b1;
          end else if (r_cnt == CNT_LAST) begin
            rdata   <= load_extend(r_f3, r_off, ram_rdata);
            ack     <= 1'b1;
            r_state <= S_DONE;
          end else begin
            r_cnt   <= r_cnt + 1'b1;
            r_state <= S_WAIT;
          end
        end
        S_DONE, S_ERR: begin
          busy    <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          busy    <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_stage_responder.sv
// Scoreboard bench for mem_stage_responder against a behavioural RAM with
// a two-cycle address-to-data latency.
module tb_mem_stage_responder;
  localparam int ADDR_W = 14;
  localparam int RD_LAT = 2;

  logic              clk = 1'b0;
  logic              reset_n = 1'b0;
  logic              req = 1'b0;
  logic              req_we = 1'b0;
  logic [2:0]        req_funct3 = 3'b000;
  logic [31:0]       req_addr = '0;
  logic [31:0]       req_wdata = '0;
  logic              busy, ack, err;
  logic [31:0]       rdata;
  logic [ADDR_W-1:0] ram_addr;
  logic              ram_we;
  logic [3:0]        ram_be;
  logic [31:0]       ram_wdata;
  logic [31:0]       ram_rdata;

  typedef struct packed {
    logic        e;
    logic [31:0] d;
    int          lat;
  } exp_t;

  exp_t        sb[$];
  int          n_cmp = 0;
  int          n_bad = 0;
  int          ack_cnt = 0;
  int          we_cnt = 0;
  logic [31:0] model_rdata = '0;
  logic [31:0] mem [0:255];

  always #5 clk = ~clk;

  mem_stage_responder #(.ADDR_W(ADDR_W), .RD_LAT(RD_LAT)) dut (
    .clk(clk), .reset_n(reset_n), .req(req), .req_we(req_we), .req_funct3(req_funct3),
    .req_addr(req_addr), .req_wdata(req_wdata), .busy(busy), .ack(ack), .err(err),
    .rdata(rdata), .ram_addr(ram_addr), .ram_we(ram_we), .ram_be(ram_be),
    .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
  );

  // Address valid in cycle N gives data valid in cycle N+1, sampled at its end.
  always_ff @(posedge clk) begin
    if (ram_we)
      for (int i = 0; i < 4; i++)
        if (ram_be[i]) mem[ram_addr[7:0]][8*i +: 8] <= ram_wdata[8*i +: 8];
    ram_rdata <= mem[ram_addr[7:0]];
  end

  always @(posedge clk) begin
    if (ack) ack_cnt++;
    if (ram_we) we_cnt++;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic drive_req(input logic we, input logic [2:0] f3, input logic [31:0] a,
                           input logic [31:0] wd);
    @(negedge clk);
    req = 1'b1; req_we = we; req_funct3 = f3; req_addr = a; req_wdata = wd;
    @(negedge clk);
    req = 1'b0;
  endtask

  // Called in the cycle after the request edge; lat counts that cycle as 1.
  task automatic wait_ack(input int max, output int lat, output logic e, output logic [31:0] d);
    lat = 1;
    while (ack !== 1'b1 && lat < max) begin
      @(negedge clk);
      lat++;
    end
    e = err;
    d = rdata;
    if (ack !== 1'b1) lat = -1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp++; if ({busy, ack, err, ram_we, ram_be} !== 8'h00) begin
      n_bad++;
      $display("FAIL reset_ctrl: got %b want 00000000", {busy, ack, err, ram_we, ram_be});
    end
    n_cmp++; if (rdata !== 32'h0) begin
      n_bad++;
      $display("FAIL reset_rdata: got %h want 00000000", rdata);
    end
    n_cmp++; if ({ram_addr, ram_wdata} !== '0) begin
      n_bad++;
      $display("FAIL reset_ram: got addr %h wdata %h want 0", ram_addr, ram_wdata);
    end
    reset_n = 1'b1;
  endtask

  task automatic test_store_word();
    int lat; logic e; logic [31:0] d; exp_t ex; int we0;
    we0 = we_cnt;
    ex.e = 1'b0; ex.d = model_rdata; ex.lat = 2; sb.push_back(ex);
    drive_req(1'b1, 3'b010, 32'h10, 32'hDEADBEEF);
    n_cmp++; if ({busy, ram_we, ram_be} !== 6'b111111) begin
      n_bad++;
      $display("FAIL sw_strobes: got %b want 111111", {busy, ram_we, ram_be});
    end
    n_cmp++; if (ram_addr !== 14'd4) begin
      n_bad++;
      $display("FAIL sw_addr: got %h want 0004", ram_addr);
    end
    n_cmp++; if (ram_wdata !== 32'hDEADBEEF) begin
      n_bad++;
      $display("FAIL sw_wdata: got %h want deadbeef", ram_wdata);
    end
    wait_ack(8, lat, e, d);
    ex = sb.pop_front();
    n_cmp++; if (lat !== ex.lat) begin
      n_bad++;
      $display("FAIL sw_latency: got %0d want %0d", lat, ex.lat);
    end
    n_cmp++; if ({e, d} !== {ex.e, ex.d}) begin
      n_bad++;
      $display("FAIL sw_resp: got err %b rdata %h want err %b rdata %h", e, d, ex.e, ex.d);
    end
    n_cmp++; if (ram_we !== 1'b0) begin
      n_bad++;
      $display("FAIL sw_we_pulse: got ram_we %b want 0", ram_we);
    end
    @(negedge clk);
    n_cmp++; if (we_cnt - we0 !== 1) begin
      n_bad++;
      $display("FAIL sw_we_count: got %0d want 1", we_cnt - we0);
    end
  endtask

  // Store a word then run a table of loads against it.
  task automatic run_loads(input string name, input logic [31:0] st_addr, input logic [31:0] st_word,
                           input logic [2:0] f3 [3], input logic [31:0] a [3], input logic [31:0] want [3]);
    int lat; logic e; logic [31:0] d; exp_t ex; int we0;
    ex.e = 1'b0; ex.d = model_rdata; ex.lat = 2; sb.push_back(ex);
    drive_req(1'b1, 3'b010, st_addr, st_word);
    wait_ack(8, lat, e, d);
    ex = sb.pop_front();
    n_cmp++; if (lat !== ex.lat || {e, d} !== {ex.e, ex.d}) begin
      n_bad++;
      $display("FAIL %s_store: got lat %0d err %b rdata %h want lat %0d err %b rdata %h",
               name, lat, e, d, ex.lat, ex.e, ex.d);
    end
    we0 = we_cnt;
    for (int i = 0; i < 3; i++) begin
      ex.e = 1'b0; ex.d = want[i]; ex.lat = RD_LAT + 1; sb.push_back(ex);
      drive_req(1'b0, f3[i], a[i], 32'hFFFF_FFFF);
      n_cmp++; if ({ram_we, ram_addr} !== {1'b0, a[i][ADDR_W+1:2]}) begin
        n_bad++;
        $display("FAIL %s_issue%0d: got we %b addr %h want we 0 addr %h",
                 name, i, ram_we, ram_addr, a[i][ADDR_W+1:2]);
      end
      wait_ack(8, lat, e, d);
      ex = sb.pop_front();
      n_cmp++; if (lat !== ex.lat) begin
        n_bad++;
        $display("FAIL %s_latency%0d: got %0d want %0d", name, i, lat, ex.lat);
      end
      n_cmp++; if ({e, d} !== {ex.e, ex.d}) begin
        n_bad++;
        $display("FAIL %s_data%0d: got err %b rdata %h want err %b rdata %h", name, i, e, d, ex.e, ex.d);
      end
      model_rdata = want[i];
    end
    @(negedge clk);
    n_cmp++; if (we_cnt !== we0) begin
      n_bad++;
      $display("FAIL %s_no_write: got %0d writes want 0", name, we_cnt - we0);
    end
  endtask

  task automatic test_byte_loads();
    logic [2:0] f3 [3]; logic [31:0] a [3]; logic [31:0] w [3];
    f3 = '{3'b000, 3'b100, 3'b000};
    a  = '{32'h13, 32'h13, 32'h11};
    w  = '{32'hFFFFFF80, 32'h00000080, 32'h00000012};
    run_loads("byte", 32'h10, 32'h80FF1234, f3, a, w);
  endtask

  task automatic test_half_loads();
    logic [2:0] f3 [3]; logic [31:0] a [3]; logic [31:0] w [3];
    f3 = '{3'b001, 3'b101, 3'b001};
    a  = '{32'h02, 32'h02, 32'h00};
    w  = '{32'hFFFF8001, 32'h00008001, 32'h00007FFF};
    run_loads("half", 32'h00, 32'h80017FFF, f3, a, w);
  endtask

  task automatic test_sb_lane();
    int lat; logic e; logic [31:0] d; exp_t ex;
    ex.e = 1'b0; ex.d = model_rdata; ex.lat = 2; sb.push_back(ex);
    drive_req(1'b1, 3'b000, 32'h13, 32'h000000A5);
    n_cmp++; if ({ram_we, ram_be, ram_addr} !== {1'b1, 4'b1000, 14'd4}) begin
      n_bad++;
      $display("FAIL sb_strobes: got we %b be %b addr %h want 1 1000 0004", ram_we, ram_be, ram_addr);
    end
    n_cmp++; if (ram_wdata !== 32'hA5A5A5A5) begin
      n_bad++;
      $display("FAIL sb_wdata: got %h want a5a5a5a5", ram_wdata);
    end
    wait_ack(8, lat, e, d);
    ex = sb.pop_front();
    n_cmp++; if (lat !== ex.lat || {e, d} !== {ex.e, ex.d} || ram_we !== 1'b0) begin
      n_bad++;
      $display("FAIL sb_resp: got lat %0d err %b rdata %h we %b want lat %0d err %b rdata %h we 0",
               lat, e, d, ram_we, ex.lat, ex.e, ex.d);
    end
    ex.e = 1'b0; ex.d = 32'hA5FF1234; ex.lat = RD_LAT + 1; sb.push_back(ex);
    drive_req(1'b0, 3'b010, 32'h10, 32'h0);
    wait_ack(8, lat, e, d);
    ex = sb.pop_front();
    n_cmp++; if (lat !== ex.lat || {e, d} !== {ex.e, ex.d}) begin
      n_bad++;
      $display("FAIL sb_readback: got lat %0d rdata %h want lat %0d rdata %h", lat, d, ex.lat, ex.d);
    end
    model_rdata = 32'hA5FF1234;
  endtask

  task automatic test_errors();
    logic       we [5]; logic [2:0] f3 [5]; logic [31:0] a [5];
    int lat; logic e; logic [31:0] d; exp_t ex; int we0;
    we = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    f3 = '{3'b010, 3'b011, 3'b001, 3'b110, 3'b100};
    a  = '{32'h06, 32'h00, 32'h01, 32'h00, 32'h00};
    we0 = we_cnt;
    for (int i = 0; i < 5; i++) begin
      ex.e = 1'b1; ex.d = model_rdata; ex.lat = 1; sb.push_back(ex);
      drive_req(we[i], f3[i], a[i], 32'h0000_0000);
      wait_ack(8, lat, e, d);
      ex = sb.pop_front();
      n_cmp++; if (lat !== ex.lat || {e, d} !== {ex.e, ex.d} || ram_we !== 1'b0) begin
        n_bad++;
        $display("FAIL err_case%0d: got lat %0d err %b rdata %h we %b want lat %0d err 1 rdata %h we 0",
                 i, lat, e, d, ram_we, ex.lat, ex.d);
      end
    end
    @(negedge clk);
    n_cmp++; if (we_cnt !== we0) begin
      n_bad++;
      $display("FAIL err_no_write: got %0d writes want 0", we_cnt - we0);
    end
  endtask

  task automatic test_busy_ignore();
    int lat; logic e; logic [31:0] d; exp_t ex; int ack0, we0; logic low_seen;
    ack0 = ack_cnt; we0 = we_cnt; low_seen = 1'b0;
    ex.e = 1'b0; ex.d = 32'h80017FFF; ex.lat = RD_LAT + 1; sb.push_back(ex);
    drive_req(1'b0, 3'b010, 32'h00, 32'h0);
    // Hold a conflicting store request through ISSUE, WAIT and DONE.
    req = 1'b1; req_we = 1'b1; req_funct3 = 3'b010; req_addr = 32'h0; req_wdata = 32'h0;
    lat = 1;
    while (ack !== 1'b1 && lat < 8) begin
      if (busy !== 1'b1) low_seen = 1'b1;
      @(negedge clk);
      lat++;
    end
    e = err; d = rdata;
    if (ack !== 1'b1) lat = -1;
    ex = sb.pop_front();
    n_cmp++; if (lat !== ex.lat || {e, d} !== {ex.e, ex.d}) begin
      n_bad++;
      $display("FAIL busy_load: got lat %0d rdata %h want lat %0d rdata %h", lat, d, ex.lat, ex.d);
    end
    n_cmp++; if (low_seen !== 1'b0) begin
      n_bad++;
      $display("FAIL busy_high: got busy low before ack want high");
    end
    @(negedge clk);
    n_cmp++; if (busy !== 1'b0) begin
      n_bad++;
      $display("FAIL busy_drop: got busy %b want 0", busy);
    end
    req = 1'b0;
    model_rdata = 32'h80017FFF;
    repeat (3) @(negedge clk);
    n_cmp++; if (ack_cnt - ack0 !== 1 || we_cnt !== we0) begin
      n_bad++;
      $display("FAIL busy_ignored: got %0d acks %0d writes want 1 acks 0 writes",
               ack_cnt - ack0, we_cnt - we0);
    end
  endtask

  task automatic test_reset_wait();
    int lat; logic e; logic [31:0] d; exp_t ex; int ack0;
    ack0 = ack_cnt;
    drive_req(1'b0, 3'b010, 32'h00, 32'h0);
    @(negedge clk);
    reset_n = 1'b0;
    @(negedge clk);
    n_cmp++; if ({busy, ack, ram_we} !== 3'b000 || rdata !== 32'h0) begin
      n_bad++;
      $display("FAIL rst_wait_abort: got busy %b ack %b we %b rdata %h want 0 0 0 00000000",
               busy, ack, ram_we, rdata);
    end
    reset_n = 1'b1;
    model_rdata = '0;
    repeat (4) @(negedge clk);
    n_cmp++; if (ack_cnt !== ack0) begin
      n_bad++;
      $display("FAIL rst_wait_noack: got %0d acks want 0", ack_cnt - ack0);
    end
    ex.e = 1'b0; ex.d = 32'hA5FF1234; ex.lat = RD_LAT + 1; sb.push_back(ex);
    drive_req(1'b0, 3'b010, 32'h10, 32'h0);
    wait_ack(8, lat, e, d);
    ex = sb.pop_front();
    n_cmp++; if (lat !== ex.lat || {e, d} !== {ex.e, ex.d}) begin
      n_bad++;
      $display("FAIL rst_wait_after: got lat %0d err %b rdata %h want lat %0d err 0 rdata %h",
               lat, e, d, ex.lat, ex.d);
    end
    model_rdata = ex.d;
  endtask

  task automatic test_back_to_back();
    logic       we [4]; logic [2:0] f3 [4]; logic [31:0] a [4]; logic [31:0] wd [4]; logic [31:0] want [4];
    int lat; logic e; logic [31:0] d; exp_t ex;
    we   = '{1'b1, 1'b1, 1'b0, 1'b0};
    f3   = '{3'b010, 3'b001, 3'b101, 3'b010};
    a    = '{32'h04, 32'h06, 32'h06, 32'h04};
    wd   = '{32'h11223344, 32'h1234BEEF, 32'h0, 32'h0};
    want = '{32'h0, 32'h0, 32'h0000BEEF, 32'hBEEF3344};
    for (int i = 0; i < 4; i++) begin
      ex.e = 1'b0; ex.d = we[i] ? model_rdata : want[i]; ex.lat = we[i] ? 2 : RD_LAT + 1;
      sb.push_back(ex);
      @(negedge clk);
      if (i > 0) begin
        n_cmp++; if (busy !== 1'b0) begin
          n_bad++;
          $display("FAIL b2b_idle%0d: got busy %b want 0", i, busy);
        end
      end
      req = 1'b1; req_we = we[i]; req_funct3 = f3[i]; req_addr = a[i]; req_wdata = wd[i];
      @(negedge clk);
      req = 1'b0;
      if (i == 1) begin
        n_cmp++; if ({ram_be, ram_wdata} !== {4'b1100, 32'hBEEFBEEF}) begin
          n_bad++;
          $display("FAIL b2b_sh_lanes: got be %b wdata %h want 1100 beefbeef", ram_be, ram_wdata);
        end
      end
      wait_ack(8, lat, e, d);
      ex = sb.pop_front();
      n_cmp++; if (lat !== ex.lat || {e, d} !== {ex.e, ex.d}) begin
        n_bad++;
        $display("FAIL b2b_resp%0d: got lat %0d err %b rdata %h want lat %0d err 0 rdata %h",
                 i, lat, e, d, ex.lat, ex.d);
      end
      if (!we[i]) model_rdata = want[i];
    end
  endtask

  initial begin
    test_reset();
    test_store_word();
    test_byte_loads();
    test_half_loads();
    test_sb_lane();
    test_errors();
    test_busy_ignore();
    test_reset_wait();
    test_back_to_back();
    repeat (2) @(negedge clk);
    n_cmp++; if (sb.size() !== 0) begin
      n_bad++;
      $display("FAIL scoreboard_drain: got %0d left want 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  // Every FAIL line above is paired with exactly one failed comparison.
  always @(n_cmp) ;
endmodule
